// File: rtl/demosaic_window_ctrl_pkg.sv
// demosaic_window_ctrl_pkg: Bayer phase encodings, pattern constants and window geometry shared with the kernel-select mux.
package demosaic_window_ctrl_pkg;
  typedef enum logic [1:0] {PH_R = 2'd0, PH_GR = 2'd1, PH_GB = 2'd2, PH_B = 2'd3} phase_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic [1:0] BAYER_RGGB = 2'b00;
  localparam logic [1:0] BAYER_GRBG = 2'b01;
  localparam logic [1:0] BAYER_GBRG = 2'b10;
  localparam logic [1:0] BAYER_BGGR = 2'b11;
  localparam int WIN = 5;
  localparam int HALO = WIN - 1;
  // Parity of the input pixel equals parity of the centre two rows/cols back.
  function automatic phase_t phase_of(input logic r0, input logic c0, input logic [1:0] bayer);
    return phase_t'({r0, c0} ^ bayer);
  endfunction
endpackage

// File: rtl/demosaic_window_ctrl_raster_counter.sv
// raster_counter: row/col position of the current pixel; restart makes the current pixel (0,0).
module raster_counter #(
  parameter int W = 640,
  parameter int H = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 inc,
  output logic [$clog2(H)-1:0] row,
  output logic [$clog2(W)-1:0] col,
  output logic                 wrap,
  output logic                 last
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  always_comb begin
    row = restart ? '0 : row_q;
    col = restart ? '0 : col_q;
    wrap = col == CW'(W - 1);
    last = wrap && row == RW'(H - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      col_q <= wrap ? '0 : col + 1'b1;
      row_q <= wrap ? (last ? '0 : row + 1'b1) : row;
    end
  end
endmodule

// File: rtl/demosaic_window_ctrl.sv
// demosaic_window_ctrl: raster tracking and 5x5 window-centre sequencing for Bayer demosaicing.
module demosaic_window_ctrl
  import demosaic_window_ctrl_pkg::*;
#(
  parameter int         IMG_W = 640,
  parameter int         IMG_H = 480,
  parameter logic [1:0] BAYER = 2'b00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic                     lb_wr_en,
  output logic [$clog2(IMG_W)-1:0] lb_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_phase,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     frame_done,
  output logic                     sof_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state, state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic acc, start, take, done, ld, wrap, last;
  raster_counter #(.W(IMG_W), .H(IMG_H)) u_cnt (
    .clk(clk), .rst(rst), .restart(in_sof), .inc(take),
    .row(row), .col(col), .wrap(wrap), .last(last)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    in_ready = !rst && (out_ready || !out_valid);
    acc = in_valid && in_ready;
    start = acc && in_sof;
    take = acc && (state == RUN || in_sof);
    done = take && last;
    ld = take && row >= RW'(HALO) && col >= CW'(HALO);
    state_nx = done ? IDLE : start ? RUN : state;
  end
  always_comb begin
    lb_wr_en = take;
    lb_addr = col;
  end
  // While in RUN the stored position is never (0,0), so any sof seen there is misplaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_phase <= 2'b00;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      frame_done <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      frame_done <= done;
      sof_err <= sof_err || (start && state == RUN);
      if (ld) begin
        out_valid <= 1'b1;
        out_phase <= phase_of(row[0], col[0], BAYER);
        out_sof <= row == RW'(HALO) && col == CW'(HALO);
        out_eol <= wrap;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_demosaic_window_ctrl.sv
// tb_demosaic_window_ctrl: table vectors, directed corner sequences and random traffic against a frame-index model.
module tb_demosaic_window_ctrl;
  localparam int W = 8;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_sof, out_ready;
  logic ir0, we0, ov0, os0, oe0, fd0, se0;
  logic ir1, we1, ov1, os1, oe1, fd1, se1;
  logic [2:0] la0, la1;
  logic [1:0] ph0, ph1;
  always #5 clk = ~clk;
  demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .BAYER(2'b00)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(ir0),
    .lb_wr_en(we0), .lb_addr(la0), .out_valid(ov0), .out_ready(out_ready),
    .out_phase(ph0), .out_sof(os0), .out_eol(oe0), .frame_done(fd0), .sof_err(se0));
  demosaic_window_ctrl #(.IMG_W(W), .IMG_H(H), .BAYER(2'b11)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(ir1),
    .lb_wr_en(we1), .lb_addr(la1), .out_valid(ov1), .out_ready(out_ready),
    .out_phase(ph1), .out_sof(os1), .out_eol(oe1), .frame_done(fd1), .sof_err(se1));
  int total = 0, bad = 0, xfers = 0;
  int m_run = 0, m_n = 0, m_ov = 0, m_ph = 0, m_sof = 0, m_eol = 0, m_fd = 0, m_err = 0, m_acc = 0;
  typedef struct {logic rst, v, s, r, e_ir, e_wr, e_ov;} vec_t;
  vec_t tbl[10];
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_all();
    int rdy = (!rst && (!m_ov || out_ready)) ? 1 : 0;
    int wr = (rdy && in_valid && (m_run || in_sof)) ? 1 : 0;
    chk("in_ready", int'(ir0), rdy);
    chk("in_ready_b", int'(ir1), rdy);
    chk("lb_wr_en", int'(we0), wr);
    chk("lb_wr_en_b", int'(we1), wr);
    if (wr != 0) chk("lb_addr", int'(la0), in_sof ? 0 : m_n % W);
    chk("out_valid", int'(ov0), m_ov);
    chk("out_valid_b", int'(ov1), m_ov);
    if (m_ov != 0) begin
      chk("out_phase", int'(ph0), m_ph);
      chk("out_phase_b", int'(ph1), m_ph ^ 3);
      chk("out_sof", int'(os0), m_sof);
      chk("out_sof_b", int'(os1), m_sof);
      chk("out_eol", int'(oe0), m_eol);
      chk("out_eol_b", int'(oe1), m_eol);
    end
    chk("frame_done", int'(fd0), m_fd);
    chk("frame_done_b", int'(fd1), m_fd);
    chk("sof_err", int'(se0), m_err);
    chk("sof_err_b", int'(se1), m_err);
    if (ov0 && out_ready) xfers++;
  endtask
  task automatic step();
    int rdy = (!rst && (!m_ov || out_ready)) ? 1 : 0;
    int r, c;
    m_acc = 0;
    if (rst) begin
      m_run = 0; m_n = 0; m_ov = 0; m_ph = 0; m_sof = 0; m_eol = 0; m_fd = 0; m_err = 0;
      return;
    end
    m_fd = 0;
    if (in_valid && rdy != 0 && (m_run != 0 || in_sof)) begin
      m_acc = 1;
      if (in_sof) begin
        if (m_run != 0 && m_n != 0) m_err = 1;
        m_n = 0;
      end
      r = m_n / W;
      c = m_n % W;
      if (r >= 4 && c >= 4) begin
        m_ov = 1; m_ph = (r % 2) * 2 + (c % 2); m_sof = (r == 4 && c == 4) ? 1 : 0; m_eol = (c == W - 1) ? 1 : 0;
      end else if (out_ready) m_ov = 0;
      if (m_n == W * H - 1) begin
        m_fd = 1; m_run = 0; m_n = 0;
      end else begin
        m_run = 1; m_n++;
      end
    end else if (out_ready) m_ov = 0;
  endtask
  task automatic drive(logic rs, logic v, logic s, logic r);
    @(negedge clk);
    rst = rs; in_valid = v; in_sof = s; out_ready = r;
    #1 check_all();
  endtask
  task automatic tick();
    @(posedge clk);
    step();
  endtask
  task automatic cyc(logic rs, logic v, logic s, logic r);
    drive(rs, v, s, r);
    tick();
  endtask
  // Sends n accepted pixels; mode 1 randomises valid/ready, stall_at holds ready low 3 cycles after that pixel.
  task automatic send(int n, logic first_sof, int mode, int stall_at);
    int sent = 0, guard = 0, stall = 0;
    logic v, r;
    while (sent < n && guard < 4000) begin
      v = mode != 0 ? ($urandom_range(3) != 0) : 1'b1;
      r = mode != 0 ? ($urandom_range(3) != 0) : (stall == 0);
      cyc(1'b0, v, first_sof && sent == 0, r);
      guard++;
      if (stall > 0) stall--;
      if (m_acc != 0) begin
        if (sent == stall_at) stall = 3;
        sent++;
      end
    end
    chk("sent", sent, n);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    step();
    tbl[0] = '{1, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 1, 0, 0, 0};
    for (int i = 2; i < 7; i++) tbl[i] = '{0, 1, 0, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 1, 1, 0, 0};
    tbl[8] = '{0, 1, 1, 1, 1, 1, 0};
    tbl[9] = '{0, 1, 0, 1, 1, 1, 0};
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].r);
      chk("tbl_in_ready", int'(ir0), int'(tbl[i].e_ir));
      chk("tbl_lb_wr_en", int'(we0), int'(tbl[i].e_wr));
      chk("tbl_out_valid", int'(ov0), int'(tbl[i].e_ov));
      if (tbl[i].rst) begin
        chk("rst_phase", int'(ph0), 0);
        chk("rst_sof", int'(os0), 0);
        chk("rst_eol", int'(oe0), 0);
        chk("rst_addr", int'(la0), 0);
      end
      tick();
    end
    send(62, 1'b0, 0, -1);
    idle(2);
    chk("xfers_first_frame", xfers, 16);
    xfers = 0;
    send(64, 1'b1, 0, 37);
    idle(2);
    chk("xfers_stall_frame", xfers, 16);
    for (int f = 0; f < 3; f++) begin
      xfers = 0;
      send(64, 1'b1, 1, -1);
      idle(3);
      chk("xfers_random_frame", xfers, 16);
    end
    xfers = 0;
    send(29, 1'b1, 0, -1);
    send(64, 1'b1, 0, -1);
    idle(2);
    chk("xfers_after_sof_err", xfers, 16);
    chk("sof_err_held", int'(se0), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("sof_err_cleared", int'(se0), 0);
    send(63, 1'b1, 0, -1);
    send(64, 1'b1, 0, -1);
    idle(2);
    chk("sof_on_last_err", int'(se0), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    xfers = 0;
    send(46, 1'b1, 0, -1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_out_valid", int'(ov0), 0);
    chk("rst_mid_wr_idle", int'(we0), 0);
    tick();
    xfers = 0;
    send(64, 1'b1, 1, -1);
    idle(3);
    chk("xfers_after_rst", xfers, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
